// File: rtl/mem_dump_sequencer.sv
// Debug-side memory dump controller: walks the data memory debug read port and
// streams every word MSB-first, one byte at a time, to the UART transmitter.
module mem_dump_sequencer #(
    parameter int NBITS     = 32,
    parameter int MEM_WORDS = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_halted,
    input  logic [NBITS-1:0] i_dbg_data,
    input  logic             i_tx_done,
    output logic [NBITS-1:0] o_dbg_addr,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BYTES = NBITS / 8;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_dbg_addr;
    logic [NBITS-1:0] r_shift;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_word_idx;
    logic [CNT_W-1:0] r_byte_cnt;

    logic [NBITS-1:0] w_shift_next;
    logic             w_last_byte;
    logic             w_last_word;

    assign w_shift_next = r_shift << 8;
    assign w_last_byte  = (r_byte_cnt == CNT_W'(BYTES - 1));
    assign w_last_word  = (r_word_idx == IDX_W'(MEM_WORDS - 1));

    // Outputs are loaded on the edge that enters their state, so every output is
    // a plain register; losing i_halted overrides any other transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_dbg_addr <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            if (r_state != S_IDLE && !i_halted) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && i_halted) begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_word_idx <= '0;
                            r_dbg_addr <= '0;
                        end
                    end
                    S_LOAD: begin
                        r_shift    <= i_dbg_data;
                        r_byte_cnt <= '0;
                        r_tx_data  <= i_dbg_data[NBITS-1 -: 8];
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND;
                    end
                    S_SEND: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_tx_done) begin
                            r_shift    <= w_shift_next;
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                            if (w_last_byte) begin
                                r_state <= S_NEXT;
                            end else begin
                                r_tx_data  <= w_shift_next[NBITS-1 -: 8];
                                r_tx_start <= 1'b1;
                                r_state    <= S_SEND;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (w_last_word) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_word_idx <= r_word_idx + IDX_W'(1);
                            r_dbg_addr <= r_dbg_addr + NBITS'(ADDR_STEP);
                            r_state    <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dbg_addr = r_dbg_addr;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Bench for mem_dump_sequencer: a timeline model of the dump (byte index, scheduled
// periods for each start/done pulse) checked every cycle, plus directed literal checks.
module tb_mem_dump_sequencer;

    localparam int NBITS     = 32;
    localparam int MEM_WORDS = 2;
    localparam int ADDR_STEP = 4;
    localparam int BYTES     = NBITS / 8;
    localparam int TOTAL     = BYTES * MEM_WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halted;
    logic [31:0] dbgData;
    logic        txDone;
    logic [31:0] dbgAddr;
    logic [7:0]  txData;
    logic        txStart;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:MEM_WORDS-1];

    int checks = 0;
    int errors = 0;

    mem_dump_sequencer #(
        .NBITS(NBITS),
        .MEM_WORDS(MEM_WORDS),
        .ADDR_STEP(ADDR_STEP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_halted(halted),
        .i_dbg_data(dbgData),
        .i_tx_done(txDone),
        .o_dbg_addr(dbgAddr),
        .o_tx_data(txData),
        .o_tx_start(txStart),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    // Combinational memory read; out-of-range addresses return a marker value.
    always_comb begin
        if (dbgAddr < 32'(MEM_WORDS * ADDR_STEP) && dbgAddr[1:0] == 2'b00)
            dbgData = mem[dbgAddr / ADDR_STEP];
        else
            dbgData = 32'hBAD0_BAD0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] byteOf(input int k);
        logic [31:0] word;
        word = mem[k / BYTES];
        return 8'((word >> ((BYTES - 1 - (k % BYTES)) * 8)) & 32'hFF);
    endfunction

    // Timeline model: c counts edges; outputs after edge c belong to period c.
    int          c = 0;
    int          k = 0;
    int          sendP = -1;
    int          ackFrom = 0;
    int          doneP = -1;
    int          idleP = -1;
    int          addrEdge = -1;
    bit          outstanding = 0;
    bit          active = 0;
    logic [31:0] mAddr = 0;
    logic [7:0]  mTxData = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c = 0; k = 0; sendP = -1; ackFrom = 0; doneP = -1; idleP = -1;
            addrEdge = -1; outstanding = 0; active = 0; mAddr = 0; mTxData = 0;
        end else begin
            c++;
            if (!active) begin
                if (start && halted) begin
                    active = 1; k = 0; mAddr = 0;
                    sendP = c + 1; ackFrom = c + 3; outstanding = 1;
                    doneP = -1; idleP = -1; addrEdge = -1;
                end
            end else if (!halted) begin
                active = 0; sendP = -1; outstanding = 0;
                doneP = -1; idleP = -1; addrEdge = -1;
            end else begin
                if (c == addrEdge) mAddr = mAddr + ADDR_STEP;
                if (c == idleP) active = 0;
                if (outstanding && c >= ackFrom && txDone) begin
                    outstanding = 0;
                    k++;
                    if (k == TOTAL) begin
                        doneP = c + 1; idleP = c + 2;
                    end else if (k % BYTES != 0) begin
                        sendP = c; ackFrom = c + 2; outstanding = 1;
                    end else begin
                        addrEdge = c + 1; sendP = c + 2; ackFrom = c + 4; outstanding = 1;
                    end
                end
            end
            if (c == sendP) mTxData = byteOf(k);
        end
    end

    bit compareEn = 0;

    always @(negedge clk) begin
        if (!rst && compareEn) begin
            checkOutput("tx_start", {31'b0, txStart}, {31'b0, c == sendP});
            checkOutput("tx_data", {24'b0, txData}, {24'b0, mTxData});
            checkOutput("dbg_addr", dbgAddr, mAddr);
            checkOutput("busy", {31'b0, busy}, {31'b0, active});
            checkOutput("done", {31'b0, done}, {31'b0, c == doneP});
        end
    end

    // UART responder: acknowledges each byte after a delay, optionally with a
    // stray pulse in the SEND cycle and random pulses while idle.
    int ackLo = 3;
    int ackHi = 3;
    bit strayEn = 0;
    int ackCnt = -1;

    always @(negedge clk) begin
        if (rst) begin
            txDone = 1'b0;
            ackCnt = -1;
        end else begin
            txDone = 1'b0;
            if (ackCnt > 0) begin
                ackCnt--;
                if (ackCnt == 0) begin
                    txDone = 1'b1;
                    ackCnt = -1;
                end
            end
            if (txStart) begin
                ackCnt = $urandom_range(ackHi, ackLo);
                if (strayEn && $urandom_range(1, 0) == 1) txDone = 1'b1;
            end else if (strayEn && !busy && $urandom_range(7, 0) == 0) begin
                txDone = 1'b1;
            end
        end
    end

    int          txCount = 0;
    int          doneCnt = 0;
    logic [7:0]  capQ[$];
    logic [31:0] addrQ[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (txStart) begin
                txCount++;
                capQ.push_back(txData);
                addrQ.push_back(dbgAddr);
            end
            if (done) doneCnt++;
        end
    end

    logic [7:0] expBytes [0:7];

    task automatic clearCapture();
        txCount = 0;
        doneCnt = 0;
        capQ.delete();
        addrQ.delete();
    endtask

    task automatic applyStimulus();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && doneCnt == 0; i++) @(negedge clk);
        checkOutput("done_within_budget", {31'b0, doneCnt > 0}, 32'd1);
    endtask

    task automatic waitTx(input int n, input int budget);
        for (int i = 0; i < budget && txCount < n; i++) @(negedge clk);
        checkOutput("tx_count_reached", {31'b0, txCount >= n}, 32'd1);
    endtask

    task automatic checkDirectedDump(input string tag);
        checkOutput({tag, "_pulses"}, capQ.size(), 32'd8);
        checkOutput({tag, "_done_count"}, doneCnt, 32'd1);
        for (int i = 0; i < 8 && i < capQ.size(); i++) begin
            checkOutput({tag, "_byte"}, {24'b0, capQ[i]}, {24'b0, expBytes[i]});
            checkOutput({tag, "_addr"}, addrQ[i], (i < 4) ? 32'd0 : 32'd4);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halted = 1'b0;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h01020304;
        expBytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

        #12;
        checkOutput("reset_dbg_addr", dbgAddr, 32'd0);
        checkOutput("reset_tx_data", {24'b0, txData}, 32'd0);
        checkOutput("reset_tx_start", {31'b0, txStart}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("model_byte0", {24'b0, byteOf(0)}, 32'hDE);
        checkOutput("model_byte7", {24'b0, byteOf(7)}, 32'h04);
        @(negedge clk) rst = 1'b0;
        compareEn = 1;

        // Directed dump with fixed 3-cycle acknowledge
        halted = 1'b1;
        clearCapture();
        applyStimulus();
        @(negedge clk);
        checkOutput("first_start_latency", {31'b0, txStart}, 32'd1);
        waitDone(200);
        repeat (3) @(negedge clk);
        checkDirectedDump("dump");
        checkOutput("idle_after_done", {31'b0, busy}, 32'd0);

        // Start without halt is ignored
        halted = 1'b0;
        clearCapture();
        applyStimulus();
        repeat (20) @(negedge clk);
        checkOutput("nohalt_pulses", txCount, 32'd0);
        checkOutput("nohalt_busy", {31'b0, busy}, 32'd0);

        // Extra starts and stray acknowledges during a dump are ignored
        halted = 1'b1;
        strayEn = 1;
        clearCapture();
        applyStimulus();
        waitTx(2, 50);
        applyStimulus();
        waitTx(5, 50);
        applyStimulus();
        waitDone(200);
        repeat (3) @(negedge clk);
        strayEn = 0;
        checkDirectedDump("ignore");

        // Abort during the second byte of word 1, then a fresh dump
        clearCapture();
        applyStimulus();
        waitTx(6, 100);
        @(negedge clk) halted = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("abort_pulses", txCount, 32'd6);
        checkOutput("abort_done", doneCnt, 32'd0);
        halted = 1'b1;
        clearCapture();
        applyStimulus();
        waitDone(200);
        repeat (3) @(negedge clk);
        checkDirectedDump("restart");

        // Asynchronous reset while waiting on byte of word 1
        clearCapture();
        applyStimulus();
        waitTx(5, 100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_dbg_addr", dbgAddr, 32'd0);
        checkOutput("async_tx_data", {24'b0, txData}, 32'd0);
        checkOutput("async_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_tx_start", {31'b0, txStart}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized runs: data, acknowledge delays, stray pulses, starts, aborts
        ackLo = 1; ackHi = 6;
        for (int r = 0; r < 40; r++) begin
            int abortAt;
            mem[0] = $urandom;
            mem[1] = $urandom;
            strayEn = ($urandom_range(1, 0) == 1);
            halted = ($urandom_range(7, 0) != 0);
            abortAt = ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 1)) : -1;
            start = 1'b1;
            for (int cy = 0; cy < 200; cy++) begin
                @(negedge clk);
                start = ($urandom_range(9, 0) == 0);
                if (cy == abortAt) halted = 1'b0;
                if (cy > 2 && !busy) break;
            end
            start = 1'b0;
            halted = 1'b0;
            repeat (2) @(negedge clk);
            halted = 1'b1;
        end

        compareEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
